// File: rtl/mult32_seq.sv
// ---------------------------------------------------------------------------
// mult32_seq
//
// Sequential 32x32 shift-add multiplier for the ALU datapath. Each accepted
// request takes exactly WIDTH iterations, one per clock edge, whatever the
// operand values. The low half of the product feeds the ALU result mux
// (slot S=3'b011). The high half is kept for a future HI-register read path.
//
// Optional feature (compile-time macro MULT32_SIGNED_EN):
//   When the macro is defined, an extra input 'sgn' is sampled together with
//   'start'. With sgn=1 both operands are treated as two's complement: their
//   magnitudes are multiplied and the 64-bit product is negated at the
//   completion edge if the operand signs differ. Without the macro the port
//   does not exist and every operation is unsigned.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while not busy
//   a      in   [WIDTH-1:0] multiplicand
//   b      in   [WIDTH-1:0] multiplier
//   sgn    in   signed request (only with MULT32_SIGNED_EN)
//   busy   out  iterations in progress
//   done   out  one-cycle pulse, hi/lo newly valid
//   hi     out  [WIDTH-1:0] product[2*WIDTH-1:WIDTH]
//   lo     out  [WIDTH-1:0] product[WIDTH-1:0]
// ---------------------------------------------------------------------------
module mult32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MULT32_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               neg_q;

   logic               accept;
   logic               last_iter;
   logic [2*WIDTH-1:0] acc_sum;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               neg_in;

   // Operand conditioning at the accept edge. In signed mode the magnitudes
   // are multiplied and the sign is re-applied at the end; the magnitude of
   // -2^(WIDTH-1) is 2^(WIDTH-1), which still fits the unsigned register.
`ifdef MULT32_SIGNED_EN
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_in = 1'b0;
      if (sgn) begin
         if (a[WIDTH-1]) a_mag = -a;
         if (b[WIDTH-1]) b_mag = -b;
         neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end
`else
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_in = 1'b0;
   end
`endif

   // State register. Reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic. A request is accepted in IDLE and also during the
   // single FIN cycle, so back-to-back operations skip IDLE entirely.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_iter  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (count == LAST_COUNT) begin
               last_iter  = 1'b1;
               state_next = FIN;
            end
         end
         FIN: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift-add step; the final step's sum is written straight to hi/lo,
   // with the sign applied in the same edge so latency is unchanged.
   always_comb begin
      acc_sum = acc + (mplier[0] ? mcand : '0);
      product = neg_q ? -acc_sum : acc_sum;
   end

   // Datapath registers. hi/lo only move at the completion edge or reset, so
   // they hold the last result while a new operation iterates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         mplier <= b_mag;
         count  <= '0;
         neg_q  <= neg_in;
      end else if (state == RUN) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (last_iter) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
         end
      end
   end

   // Handshake outputs decode directly from the state register.
   assign busy = (state == RUN);
   assign done = (state == FIN);

endmodule

// File: tb/tb_mult32_seq.sv
// ---------------------------------------------------------------------------
// tb_mult32_seq
//
// Self-checking bench for mult32_seq. Expected products are pushed to a
// queue when an operation is launched and popped by a monitor whenever the
// DUT pulses done. Hand-written sequences cover latency, ignored requests,
// back-to-back operation and reset during an operation. Signed vectors are
// compiled in only when MULT32_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_mult32_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
`ifdef MULT32_SIGNED_EN
   logic        sgn;
`endif
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vecCount  = 0;
   int missCount = 0;

   logic [63:0] expQ[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vecs[$];

   mult32_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef MULT32_SIGNED_EN
      .sgn   (sgn),
`endif
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: every done pulse must match the oldest pending
   // expectation; a pulse with nothing pending is itself an error.
   always @(negedge clk) begin
      if (rst_n && done) begin
         logic [63:0] expv;
         vecCount++;
         if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL unexpectedDone: got hi=%h lo=%h, no result pending", hi, lo);
         end else begin
            expv = expQ.pop_front();
            if ({hi, lo} !== expv) begin
               missCount++;
               $display("[TB] FAIL product: got %h_%h, expected %h_%h",
                        hi, lo, expv[63:32], expv[31:0]);
            end
         end
      end
   end

   // Small model of the ALU 8x1 result mux; slot 3 carries the multiplier LO.
   function automatic logic [31:0] aluMux(input logic [2:0] s, input logic [31:0] mulLo);
      case (s)
         3'b011:  return mulLo;
         default: return 32'hA5A5_0000 | {29'd0, s};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Launch one operation, record its expected product and wait (bounded)
   // for it to complete. Operands are scrambled right after the start edge.
   task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                input logic vs, input logic [63:0] expv);
      int cyc;
      @(negedge clk);
      a     = va;
      b     = vb;
`ifdef MULT32_SIGNED_EN
      sgn   = vs;
`endif
      start = 1'b1;
      expQ.push_back(expv);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
`ifdef MULT32_SIGNED_EN
      sgn   = ~vs;
`endif
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL doneTimeout: done=%b after %0d cycles, expected 1", done, cyc);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] rp;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
`ifdef MULT32_SIGNED_EN
      sgn   = 1'b0;
`endif

      // Unsigned reference vectors.
      vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F});
      vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF});
      vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000});
      vecs.push_back('{32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0000_0001, 32'h2345_6780});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE});
      vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000});
`ifdef MULT32_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001});
      vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF2});
`endif
      // The all-ones case goes last so the ALU mux check sees its LO.
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});

      // Reset held for two cycles, then released with start low.
      repeat (2) @(negedge clk);
      checkOutput("resetHeld", {30'd0, busy, done, hi, lo}, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("resetReleased", {30'd0, busy, done, hi, lo}, 64'd0);

      // Latency sequence: 3x5 launched, stray 7x7 request mid-run, then a
      // second request held during the FIN cycle.
      a     = 32'd3;
      b     = 32'd5;
      start = 1'b1;
      expQ.push_back(64'h0000_0000_0000_000F);
      @(negedge clk);
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1357_9BDF;
      checkOutput("busyAfterE0", {62'd0, busy, done}, 64'd2);
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         checkOutput($sformatf("runE%0d", k), {62'd0, busy, done}, 64'd2);
         if (k == 9) begin
            a     = 32'd7;
            b     = 32'd7;
            start = 1'b1;
         end else if (k == 10) begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput("doneAfterE32", {62'd0, busy, done}, 64'd1);
      a     = 32'd2;
      b     = 32'h8000_0000;
      start = 1'b1;
      expQ.push_back(64'h0000_0001_0000_0000);
      @(negedge clk);
      start = 1'b0;
      checkOutput("backToBackE33", {62'd0, busy, done}, 64'd2);
      for (int k = 34; k <= 64; k++) begin
         @(negedge clk);
         if (done) checkOutput($sformatf("earlyDoneE%0d", k), {63'd0, done}, 64'd0);
      end
      @(negedge clk);
      checkOutput("doneAfterE65", {62'd0, busy, done}, 64'd1);
      @(negedge clk);
      checkOutput("idleAfterE66", {62'd0, busy, done}, 64'd0);

      // Reset in the middle of an operation: outputs clear at once and the
      // abandoned operation never reports completion.
      a     = 32'd9;
      b     = 32'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetClears", {30'd0, busy, done, hi, lo}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("noDoneAfterAbort", {30'd0, busy, done, hi, lo}, 64'd0);
      applyStimulus(32'd5, 32'd6, 1'b0, 64'd30);

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, {vecs[i].expHi, vecs[i].expLo});
      end
      checkOutput("aluMuxSlot3", {32'd0, aluMux(3'b011, lo)}, 64'h0000_0000_0000_0001);
      checkOutput("loHeldIdle", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // A few random unsigned operands against a plain 64-bit product.
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         rp = 64'(ra) * 64'(rb);
         applyStimulus(ra, rb, 1'b0, rp);
      end

      checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
